// File: rtl/multisum_feeder_pkg.sv
// Shared definitions for MultiSum initiators: FSM state encoding and adder-tree fan-in.
package multisum_feeder_pkg;

  localparam int MS_FANIN = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_WAIT,
    ST_FIN,
    ST_ERR
  } ms_state_e;

endpackage

// File: rtl/multisum_feeder_buf.sv
// Operand register file: one write port, three combinational read ports.
// Out-of-range reads return zero; out-of-range writes are dropped.
module multisum_feeder_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 12,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr0,
  input  logic [AW-1:0]    raddr1,
  input  logic [AW-1:0]    raddr2,
  output logic [WIDTH-1:0] rdata0,
  output logic [WIDTH-1:0] rdata1,
  output logic [WIDTH-1:0] rdata2
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we && ({1'b0, waddr} < DEPTH_W)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata0 = ({1'b0, raddr0} < DEPTH_W) ? mem[raddr0] : '0;
  assign rdata1 = ({1'b0, raddr1} < DEPTH_W) ? mem[raddr1] : '0;
  assign rdata2 = ({1'b0, raddr2} < DEPTH_W) ? mem[raddr2] : '0;

endmodule

// File: rtl/multisum_feeder.sv
// Reduces a buffered operand vector to one sum via chained MultiSum start/done transactions.
// Per transaction SETUP+PULSE+WAIT cycles, plus one FIN cycle; writes and go are ignored while busy.
module multisum_feeder
  import multisum_feeder_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 12,
  parameter int AW      = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    len,
  input  logic             go,
  output logic             busy,
  output logic [WIDTH-1:0] ms_in0,
  output logic [WIDTH-1:0] ms_in1,
  output logic [WIDTH-1:0] ms_in2,
  output logic [WIDTH-1:0] ms_in3,
  output logic             ms_start,
  input  logic [WIDTH-1:0] ms_sum,
  input  logic             ms_done,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             error
);

  localparam int          CW      = $clog2(TIMEOUT + 1);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0] STEP_W  = (AW+1)'(MS_FANIN - 1);
  localparam logic [CW-1:0] TO_W  = CW'(TIMEOUT);

  ms_state_e        state, nstate;
  logic [AW:0]      n, idx;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    wcnt;
  logic             ms_done_q;
  logic             done_edge;
  logic [AW:0]      len_clamp;
  logic [AW:0]      s0, s1, s2;
  logic [WIDTH-1:0] rd0, rd1, rd2;

  assign done_edge = ms_done & ~ms_done_q;
  assign len_clamp = ({1'b0, len} > DEPTH_W) ? DEPTH_W : {1'b0, len};
  assign s0 = idx;
  assign s1 = idx + (AW+1)'(1);
  assign s2 = idx + (AW+1)'(2);

  multisum_feeder_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_buf (
    .clk    (clk),
    .we     (wr_en & ~busy),
    .waddr  (wr_addr),
    .wdata  (wr_data),
    .raddr0 (s0[AW-1:0]),
    .raddr1 (s1[AW-1:0]),
    .raddr2 (s2[AW-1:0]),
    .rdata0 (rd0),
    .rdata1 (rd1),
    .rdata2 (rd2)
  );

  always_comb begin
    nstate   = state;
    ms_start = 1'b0;
    case (state)
      ST_IDLE:  if (go) nstate = (len_clamp == '0) ? ST_FIN : ST_SETUP;
      ST_SETUP: nstate = ST_PULSE;
      ST_PULSE: begin
        nstate   = ST_WAIT;
        ms_start = 1'b1;
      end
      ST_WAIT: begin
        if (done_edge) nstate = ((idx + STEP_W) < n) ? ST_SETUP : ST_FIN;
        else if (wcnt == TO_W) nstate = ST_ERR;
      end
      ST_FIN:  nstate = ST_IDLE;
      ST_ERR:  nstate = ST_IDLE;
      default: nstate = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      n         <= '0;
      idx       <= '0;
      acc       <= '0;
      wcnt      <= '0;
      ms_in0    <= '0;
      ms_in1    <= '0;
      ms_in2    <= '0;
      ms_in3    <= '0;
      result    <= '0;
      done      <= 1'b0;
      error     <= 1'b0;
      ms_done_q <= 1'b0;
    end else begin
      state     <= nstate;
      ms_done_q <= ms_done;
      done      <= 1'b0;
      error     <= 1'b0;
      case (state)
        ST_IDLE: if (go) begin
          n    <= len_clamp;
          idx  <= '0;
          acc  <= '0;
          busy <= 1'b1;
        end
        // Slots past the run length feed zeros so the adder tree sees a neutral operand.
        ST_SETUP: begin
          ms_in0 <= acc;
          ms_in1 <= (s0 < n) ? rd0 : '0;
          ms_in2 <= (s1 < n) ? rd1 : '0;
          ms_in3 <= (s2 < n) ? rd2 : '0;
        end
        ST_PULSE: wcnt <= CW'(1);
        ST_WAIT: begin
          if (done_edge) begin
            acc <= ms_sum;
            idx <= idx + STEP_W;
          end else begin
            wcnt <= wcnt + CW'(1);
          end
        end
        ST_FIN: begin
          result <= acc;
          done   <= 1'b1;
          busy   <= 1'b0;
        end
        ST_ERR: begin
          error <= 1'b1;
          busy  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multisum_feeder.sv
// Bench for multisum_feeder: table vectors, hand-written corner sequences and random runs
// against a MultiSum model and a sum/partial-sum reference computed from a shadow buffer.
module tb_multisum_feeder;

  localparam int W  = 32;
  localparam int D  = 12;
  localparam int AW = 4;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          reset, wr_en, go, ms_done;
  logic [AW-1:0] wr_addr, len;
  logic [W-1:0]  wr_data, ms_sum;
  logic          busy, ms_start, done, error;
  logic [W-1:0]  ms_in0, ms_in1, ms_in2, ms_in3, result;

  multisum_feeder #(.WIDTH(W), .DEPTH(D), .AW(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .len(len), .go(go), .busy(busy), .ms_in0(ms_in0), .ms_in1(ms_in1),
    .ms_in2(ms_in2), .ms_in3(ms_in3), .ms_start(ms_start), .ms_sum(ms_sum),
    .ms_done(ms_done), .result(result), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] i0, i1, i2, i3;
  } grp_t;

  typedef struct {
    int           len;
    int           nload;
    logic [W-1:0] exp_res;
    int           exp_tx;
  } vec_t;

  int pass_cnt = 0, chk_cnt = 0;
  int cyc = 0;
  grp_t cap[$];
  int done_cnt = 0, err_cnt = 0, done_cyc = 0, err_cyc = 0, start_cyc = 0, go_cyc = 0;
  bit hang = 1'b0, pend = 1'b0;
  int lat = 0, hold = 0;
  logic [W-1:0] psum;
  logic [W-1:0] sh [D];

  always @(posedge clk) cyc++;

  // MultiSum model plus output monitor, all sampled mid-cycle.
  always @(negedge clk) begin
    if (ms_start) begin
      cap.push_back('{ms_in0, ms_in1, ms_in2, ms_in3});
      start_cyc = cyc;
      pend = !hang;
      lat  = $urandom_range(3, 7);
      psum = ms_in0 + ms_in1 + ms_in2 + ms_in3;
    end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (error) begin err_cnt++; err_cyc = cyc; end
    if (hold > 0) begin
      hold--;
      if (hold == 0) ms_done = 1'b0;
    end
    if (pend && !ms_start) begin
      if (lat == 0) begin
        ms_sum  = psum;
        ms_done = 1'b1;
        hold    = 2;
        pend    = 1'b0;
      end else begin
        lat--;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    else pass_cnt++;
  endtask

  task automatic wr(input int a, input logic [W-1:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a[AW-1:0]; wr_data = d;
    if (a < D) sh[a] = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic start_run(input int l, input bit samew, input int wa, input logic [W-1:0] wd);
    cap.delete(); done_cnt = 0; err_cnt = 0;
    @(negedge clk);
    len = l[AW-1:0]; go = 1'b1; go_cyc = cyc;
    if (samew) begin
      wr_en = 1'b1; wr_addr = wa[AW-1:0]; wr_data = wd;
      if (wa < D) sh[wa] = wd;
    end
    @(negedge clk);
    go = 1'b0; wr_en = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    for (int k = 0; k < 400 && done_cnt == 0 && err_cnt == 0; k++) @(negedge clk);
    chk({tag, ".finished"}, (done_cnt + err_cnt) != 0, 1);
    repeat (2) @(negedge clk);
  endtask

  // Expected groups: in0 is the sum of all earlier operands, in1..3 the next three (zero past n).
  task automatic check_run(input int l, input string tag);
    int n, ntx, ix;
    logic [W-1:0] acc, e, sum;
    logic [W-1:0] op [4];
    grp_t gg;
    n   = (l > D) ? D : l;
    ntx = (n + 2) / 3;
    chk({tag, ".tx"}, cap.size(), ntx);
    acc = '0;
    for (int g = 0; g < cap.size() && g < ntx; g++) begin
      gg = cap[g];
      op[0] = gg.i0; op[1] = gg.i1; op[2] = gg.i2; op[3] = gg.i3;
      chk($sformatf("%s.g%0d.in0", tag, g), op[0], acc);
      for (int k = 1; k < 4; k++) begin
        ix = 3 * g + k - 1;
        e  = (ix < n) ? sh[ix] : '0;
        chk($sformatf("%s.g%0d.in%0d", tag, g, k), op[k], e);
        acc = acc + e;
      end
    end
    sum = '0;
    for (int i = 0; i < n; i++) sum = sum + sh[i];
    chk({tag, ".result"}, result, sum);
    chk({tag, ".done_cnt"}, done_cnt, 1);
    chk({tag, ".err_cnt"}, err_cnt, 0);
    chk({tag, ".busy"}, busy, 0);
  endtask

  initial begin
    vec_t vt[6];
    logic [W-1:0] prev;
    int lw;
    vt[0] = '{3, 3, 6, 1};
    vt[1] = '{7, 7, 28, 3};
    vt[2] = '{0, 0, 0, 0};
    vt[3] = '{15, 12, 78, 4};
    vt[4] = '{4, 0, 10, 2};
    vt[5] = '{12, 0, 78, 4};

    reset = 1'b1; wr_en = 1'b0; go = 1'b0; ms_done = 1'b0; ms_sum = '0;
    wr_addr = '0; wr_data = '0; len = '0;
    repeat (3) @(negedge clk);
    chk("rst.busy", busy, 0);
    chk("rst.ms_start", ms_start, 0);
    chk("rst.ms_in0", ms_in0, 0);
    chk("rst.ms_in1", ms_in1, 0);
    chk("rst.ms_in2", ms_in2, 0);
    chk("rst.ms_in3", ms_in3, 0);
    chk("rst.result", result, 0);
    chk("rst.done", done, 0);
    chk("rst.error", error, 0);
    reset = 1'b0;

    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < vt[v].nload; i++) wr(i, W'(i + 1));
      start_run(vt[v].len, 1'b0, 0, '0);
      wait_end($sformatf("vec%0d", v));
      check_run(vt[v].len, $sformatf("vec%0d", v));
      chk($sformatf("vec%0d.tbl_result", v), result, vt[v].exp_res);
      chk($sformatf("vec%0d.tbl_tx", v), cap.size(), vt[v].exp_tx);
      if (vt[v].len == 0) chk("len0.done_lat", done_cyc - go_cyc, 2);
    end

    // Clamped run with a write and a second go arriving mid-run; both must be ignored.
    start_run(15, 1'b0, 0, '0);
    repeat (3) @(negedge clk);
    wr_en = 1'b1; wr_addr = '0; wr_data = 100; go = 1'b1; len = 4'd1;
    @(negedge clk);
    wr_en = 1'b0; go = 1'b0;
    wait_end("busy_ign");
    check_run(15, "busy_ign");
    chk("busy_ign.result78", result, 78);
    start_run(1, 1'b0, 0, '0);
    wait_end("buf_kept");
    check_run(1, "buf_kept");

    // MultiSum never answers.
    prev = result;
    hang = 1'b1;
    start_run(3, 1'b0, 0, '0);
    wait_end("tmo");
    chk("tmo.err_cnt", err_cnt, 1);
    chk("tmo.done_cnt", done_cnt, 0);
    chk("tmo.result_held", result, prev);
    chk("tmo.busy", busy, 0);
    lw = err_cyc - (start_cyc + 1);
    chk("tmo.latency_in_window", (lw >= TO) && (lw <= TO + 1), 1);
    hang = 1'b0;

    // Reset while waiting on MultiSum; its late done must be ignored.
    start_run(3, 1'b0, 0, '0);
    for (int k = 0; k < 20 && cap.size() == 0; k++) @(negedge clk);
    chk("rstmid.started", cap.size(), 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rstmid.busy", busy, 0);
    chk("rstmid.ms_start", ms_start, 0);
    chk("rstmid.result", result, 0);
    repeat (15) @(negedge clk);
    chk("rstmid.no_done", done_cnt, 0);
    chk("rstmid.no_err", err_cnt, 0);
    chk("rstmid.busy_after", busy, 0);
    wr(0, 4); wr(1, 5); wr(2, 6);
    start_run(3, 1'b0, 0, '0);
    wait_end("after_rst");
    check_run(3, "after_rst");
    chk("after_rst.result15", result, 15);

    // Random writes (some out of range), random length, optional write in the go cycle.
    for (int it = 0; it < 10; it++) begin
      repeat ($urandom_range(1, 5)) wr($urandom_range(0, 15), $urandom);
      lw = $urandom_range(0, 15);
      start_run(lw, 1'($urandom_range(0, 1)), $urandom_range(0, 11), $urandom);
      wait_end($sformatf("rnd%0d", it));
      check_run(lw, $sformatf("rnd%0d", it));
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
